as_result_fifo: RTL and testbench
=================================

AS_RESULT_FIFO -- requirements
Module: as_result_fifo

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries, power of two, minimum 2.
REQ-002 Parameter WIDTH, default `data_width+1: result width, matching the add/sub result port.
REQ-003 Port clk, input, 1: rising-edge clock for all state.
REQ-004 Port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port res_valid, input, 1: add/sub result on res_in is valid this cycle.
REQ-006 Port res_in, input, WIDTH: add/sub result (carry/borrow bit in MSB).
REQ-007 Port opcode_in, input, 1: opcode that produced res_in (0 add, 1 sub).
REQ-008 Port out_valid, output, 1: head entry is available.
REQ-009 Port out_ready, input, 1: consumer accepts head entry.
REQ-010 Port out_data, output, WIDTH: head result.
REQ-011 Port out_opcode, output, 1: head opcode tag.
REQ-012 Port count, output, $clog2(DEPTH)+1: current occupancy.
REQ-013 Ports full and empty, output, 1 each: occupancy flags.

Function
REQ-014 Push condition: res_valid && (!full || pop); pop condition: out_valid && out_ready.
REQ-015 Storage is first-word-fall-through: an entry pushed at edge N gives out_valid=1 in the cycle after edge N.
REQ-016 Each entry stores {opcode_in, res_in} as one word; out_data and out_opcode are that word split.
REQ-017 out_data and out_opcode are driven 0 while empty=1.
REQ-018 Read/write pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full = MSBs differ and the low bits are equal.
REQ-019 count: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-020 Full with push and pop in the same cycle: both occur, count stays DEPTH, order is preserved.
REQ-021 Empty with push: only the push occurs; there is no bypass and no same-cycle output.
REQ-022 Full with res_valid and no pop: the result is dropped and storage is unchanged.
REQ-023 out_valid = !empty, with no combinational path from out_ready to out_valid.

Reset
REQ-024 Asserting reset_n low asynchronously clears both pointers and count (and drop_cnt when present).
REQ-025 During reset: out_valid=0, empty=1, full=0, out_data=0, out_opcode=0.
REQ-026 Reset mid-operation discards all stored entries.
REQ-027 Memory contents are not reset.
REQ-028 Reset release is synchronous to clk, so the first push is possible on the first edge after release.

Configuration
REQ-029 Macro AS_RESFIFO_DROPCNT_EN, when defined, adds output drop_cnt, 8 bits.
REQ-030 drop_cnt increments on each dropped result (REQ-022) and saturates at 255.
REQ-031 Without AS_RESFIFO_DROPCNT_EN, the drop_cnt port and its logic are absent and all other behaviour is identical.

Structure
REQ-032 Package as_pkg (in defines scope) holds typedef as_entry_t as a packed {opcode, result} word and constant AS_RESFIFO_DEPTH_DEF=8.
REQ-033 Sub-module as_fifo_ram holds the storage: 1 write port and 1 asynchronous read port, DEPTH x (WIDTH+1).
REQ-034 Pointer, count and flag logic live in as_result_fifo.

Verification (`data_width=8, DEPTH=4)
REQ-035 Reset, then push 9'h1FF (opcode 1) with out_ready=0 -> next cycle out_valid=1, out_data=9'h1FF, out_opcode=1, count=1.
REQ-036 Push 4 results 1,2,3,4, then res_valid with 5 and out_ready=0 -> full=1, count=4, 5 is dropped (drop_cnt=1 with macro), pops return 1,2,3,4.
REQ-037 Full, then res_valid=1 with value 6 and out_ready=1 for one cycle -> 1 is popped, 6 is accepted, count stays 4, later order is 2,3,4,6.
REQ-038 Push and pop continuously for 10 results (0..9) -> all 10 emerge in order, and pointers wrap twice without error.
REQ-039 Reset_n pulsed low mid-cycle with count=3 -> out_valid=0 and count=0 immediately, with no clk edge needed.
REQ-040 With the macro, 300 dropped pushes while full -> drop_cnt=255.

Source files
------------

// File: rtl/as_pkg.sv
// Shared types and constants for the add/sub result FIFO.
// `DATA_WIDTH sets the add/sub operand width; the FIFO result word is one bit wider.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package as_pkg;

    localparam int AS_RESFIFO_DEPTH_DEF = 8;

    // One stored FIFO word: the opcode tag above the add/sub result (carry/borrow in MSB)
    typedef struct packed {
        logic                 opcode;
        logic [`DATA_WIDTH:0] result;
    } as_entry_t;

endpackage

// File: rtl/as_fifo_ram.sv
// FIFO storage: one synchronous write port and one asynchronous read port.
// Contents are deliberately not reset; occupancy is tracked by the pointers.
module as_fifo_ram #(
    parameter int DEPTH  = 8,
    parameter int WORD_W = 10
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WORD_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Write the incoming word on a push
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/as_result_fifo.sv
// First-word-fall-through FIFO for add/sub results tagged with their opcode.
// Optional feature: define AS_RESFIFO_DROPCNT_EN to add an 8-bit saturating
// drop_cnt output counting results dropped because the FIFO was full.
module as_result_fifo
    import as_pkg::*;
#(
    parameter int DEPTH = AS_RESFIFO_DEPTH_DEF,
    parameter int WIDTH = `DATA_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   res_valid,
    input  logic [WIDTH-1:0]       res_in,
    input  logic                   opcode_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_opcode,
    output logic [$clog2(DEPTH):0] count,
`ifdef AS_RESFIFO_DROPCNT_EN
    output logic [7:0]             drop_cnt,
`endif
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  count_q;
    logic           push;
    logic           pop;
    logic [WIDTH:0] head_word;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_valid = !empty;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a result
    assign pop  = out_valid && out_ready;
    assign push = res_valid && (!full || pop);

    as_fifo_ram #(
        .DEPTH  (DEPTH),
        .WORD_W (WIDTH + 1)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({opcode_in, res_in}),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (head_word)
    );

    // Head word is masked to zero while empty so stale memory never leaks out
    assign out_data   = empty ? '0 : head_word[WIDTH-1:0];
    assign out_opcode = empty ? 1'b0 : head_word[WIDTH];
    assign count      = count_q;

    // Advance pointers and occupancy on push/pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + PW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - PW'(1);
            end
        end
    end

`ifdef AS_RESFIFO_DROPCNT_EN
    // Count results lost to a full FIFO, saturating at 255
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if (res_valid && !push && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_as_result_fifo.sv
// Bench for as_result_fifo with DEPTH=4 and a 9-bit result word.
// The reference is a queue of {opcode, result} entries plus a drop counter.
module tb_as_result_fifo;
    import as_pkg::*;

    localparam int DEPTH = 4;
    localparam int WIDTH = `DATA_WIDTH + 1;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   res_valid;
    logic [WIDTH-1:0]       res_in;
    logic                   opcode_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic                   out_opcode;
    logic [$clog2(DEPTH):0] count;
    logic                   full;
    logic                   empty;
`ifdef AS_RESFIFO_DROPCNT_EN
    logic [7:0]             drop_cnt;
`endif

    int tests = 0;
    int fails = 0;

    as_entry_t model_q[$];
    int        model_drops = 0;

    always #5 clk = ~clk;

    as_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .res_valid  (res_valid),
        .res_in     (res_in),
        .opcode_in  (opcode_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_opcode (out_opcode),
        .count      (count),
`ifdef AS_RESFIFO_DROPCNT_EN
        .drop_cnt   (drop_cnt),
`endif
        .full       (full),
        .empty      (empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every visible output against the reference queue
    task automatic check_all(input string tag);
        as_entry_t head;
        int        n;
        n    = model_q.size();
        head = (n > 0) ? model_q[0] : '0;
        chk({tag, ".out_valid"},  32'(out_valid),  32'(n > 0));
        chk({tag, ".empty"},      32'(empty),      32'(n == 0));
        chk({tag, ".full"},       32'(full),       32'(n == DEPTH));
        chk({tag, ".count"},      32'(count),      32'(n));
        chk({tag, ".out_data"},   32'(out_data),   32'(head.result));
        chk({tag, ".out_opcode"}, 32'(out_opcode), 32'(head.opcode));
`ifdef AS_RESFIFO_DROPCNT_EN
        chk({tag, ".drop_cnt"},   32'(drop_cnt),   32'(model_drops));
`endif
    endtask

    // Apply the current inputs for one clock edge, update the reference, then check
    task automatic cycle(input string tag);
        bit        do_pop;
        bit        do_push;
        as_entry_t e;
        do_pop  = (model_q.size() > 0) && out_ready;
        do_push = res_valid && ((model_q.size() < DEPTH) || do_pop);
        e.opcode = opcode_in;
        e.result = res_in;
        if (res_valid && !do_push && model_drops < 255) model_drops++;
        @(posedge clk);
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(e);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit v, input int d, input bit op, input bit rdy);
        res_valid = v;
        res_in    = WIDTH'(d);
        opcode_in = op;
        out_ready = rdy;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_q.delete();
        model_drops = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0);

        // Reset state with an active push request held off by reset
        drive(1, 9'h155, 1, 1);
        @(posedge clk);
        #1;
        check_all("reset_hold");
        drive(0, 0, 0, 0);
        do_reset();
        check_all("after_reset");

        // Single push of all-ones with opcode sub, no consumer
        drive(1, 9'h1FF, 1, 0);
        cycle("push_1ff");
        drive(0, 0, 0, 0);
        cycle("hold_1ff");
        drive(0, 0, 0, 1);
        cycle("pop_1ff");

        // Fill to DEPTH, then drop a result while full
        for (int i = 1; i <= 4; i++) begin
            drive(1, i, i[0], 0);
            cycle("fill");
        end
        drive(1, 5, 1, 0);
        cycle("drop_5");
        drive(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle("drain");
        cycle("drain_empty");

        // Full with simultaneous push and pop keeps count and order
        for (int i = 1; i <= 4; i++) begin
            drive(1, i, 0, 0);
            cycle("refill");
        end
        drive(1, 6, 1, 1);
        cycle("full_pushpop");
        drive(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle("drain2");

        // Empty with push and ready: no bypass, then continuous streaming 0..9
        for (int i = 0; i < 10; i++) begin
            drive(1, i, i[1], 1);
            cycle("stream");
        end
        drive(0, 0, 0, 1);
        cycle("stream_tail");
        cycle("stream_empty");

        // Asynchronous reset mid-cycle with three entries stored
        for (int i = 0; i < 3; i++) begin
            drive(1, 9'h0A0 + i, 0, 0);
            cycle("pre_async");
        end
        drive(0, 0, 0, 0);
        #3;
        reset_n = 1'b0;
        model_q.delete();
        model_drops = 0;
        #1;
        check_all("async_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_all("post_async");

        // Randomized traffic against the queue reference
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), int'($urandom), 1'($urandom),
                  1'($urandom_range(0, 2) == 0));
            cycle("random");
        end

`ifdef AS_RESFIFO_DROPCNT_EN
        // Saturation of the drop counter
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, i, 0, 0);
            cycle("sat_fill");
        end
        for (int i = 0; i < 300; i++) begin
            drive(1, i, 1, 0);
            @(posedge clk);
        end
        #1;
        chk("drop_cnt_sat", 32'(drop_cnt), 32'd255);
        chk("sat_count", 32'(count), 32'(DEPTH));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
